// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes,
// opcode/funct fields, ALUOp selectors, ALUControl codes and the control bundle.
package mips_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUCTL_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // ADD is the all-zero code so states that leave ALUOp alone compute PC+x
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_MUL = 6'b011000;

    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_NOP = 3'b011;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b100;
    localparam logic [ALUCTL_W-1:0] ALU_MUL = 3'b101;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b110;

    // Per-state datapath control bundle produced by the FSM output decode
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        aluop_t     alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// alu_decoder: maps ALUOp and the R-type funct field onto the ALU_32bit op code.
// Ports: i_alu_op (ALUOp selector), i_funct (instr[5:0]), o_alu_control (3-bit ALU code).
module alu_decoder
    import mips_pkg::*;
(
    input  aluop_t               i_alu_op,
    input  logic [FUNCT_W-1:0]   i_funct,
    output logic [ALUCTL_W-1:0]  o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_control = ALU_ADD;
                    FN_SUB:  o_alu_control = ALU_SUB;
                    FN_AND:  o_alu_control = ALU_AND;
                    FN_OR:   o_alu_control = ALU_OR;
                    FN_SLT:  o_alu_control = ALU_SLT;
                    FN_MUL:  o_alu_control = ALU_MUL;
                    // unknown funct: ALU yields 0, writeback still happens
                    default: o_alu_control = ALU_NOP;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/
// memory/writeback and driving datapath selects, write enables and ALUControl.
// Inputs : CLK, RST (async active-high), Op, Funct, Zero.
// Outputs: IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//          ALUSrcB, PCSrc, PCEn, ALUControl, IllegalOp, State (debug).
// Optional: MIPS_CTRL_BNE_EN adds bne (opcode 000101) via the BRANCH state.
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [OP_W-1:0]      Op,
    input  logic [FUNCT_W-1:0]   Funct,
    input  logic                 Zero,
    output logic                 IorD,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSrc,
    output logic                 PCEn,
    output logic [ALUCTL_W-1:0]  ALUControl,
    output logic                 IllegalOp,
    output logic [STATE_W-1:0]   State
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctl;
    logic   w_illegal;
    logic   w_take;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

`ifdef MIPS_CTRL_BNE_EN
    logic r_bne;

    // Remember whether the branch being resolved is bne (captured in DECODE)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                       r_bne <= 1'b0;
        else if (r_state == S_DECODE)  r_bne <= (Op == OP_BNE);
    end

    assign w_take = r_bne ? ~Zero : Zero;
`else
    assign w_take = Zero;
`endif

    // Next-state and per-state control decode
    always_comb begin
        w_next    = r_state;
        w_ctl     = '0;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ctl.ir_write  = 1'b1;
                w_ctl.pc_write  = 1'b1;
                w_ctl.alu_src_b = 2'b01;
                w_next          = S_DECODE;
            end
            S_DECODE: begin
                w_ctl.alu_src_b = 2'b11;
                case (Op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       w_next = S_BRANCH;
`endif
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = 2'b10;
                if (r_state == S_ADDIEX) w_next = S_ADDIWB;
                else if (Op == OP_SW)    w_next = S_MEMWR;
                else                     w_next = S_MEMRD;
            end
            S_MEMRD: begin
                w_ctl.iord = 1'b1;
                w_next     = S_MEMWB;
            end
            S_MEMWB: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.mem_to_reg = 1'b1;
                w_next           = S_FETCH;
            end
            S_MEMWR: begin
                w_ctl.iord      = 1'b1;
                w_ctl.mem_write = 1'b1;
                w_next          = S_FETCH;
            end
            S_EXEC: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_op    = ALUOP_FUNCT;
                w_next          = S_ALUWB;
            end
            S_ALUWB: begin
                w_ctl.reg_write = 1'b1;
                w_ctl.reg_dst   = 1'b1;
                w_next          = S_FETCH;
            end
            S_ADDIWB: begin
                w_ctl.reg_write = 1'b1;
                w_next          = S_FETCH;
            end
            S_BRANCH: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_op    = ALUOP_SUB;
                w_ctl.pc_src    = 2'b01;
                w_ctl.branch    = 1'b1;
                w_next          = S_FETCH;
            end
            S_JUMP: begin
                w_ctl.pc_src   = 2'b10;
                w_ctl.pc_write = 1'b1;
                w_next         = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_ctl.alu_op),
        .i_funct       (Funct),
        .o_alu_control (ALUControl)
    );

    // Write enables are masked by RST so an async reset cuts them immediately
    assign IorD      = w_ctl.iord;
    assign MemWrite  = w_ctl.mem_write & ~RST;
    assign IRWrite   = w_ctl.ir_write  & ~RST;
    assign RegDst    = w_ctl.reg_dst;
    assign MemtoReg  = w_ctl.mem_to_reg;
    assign RegWrite  = w_ctl.reg_write & ~RST;
    assign ALUSrcA   = w_ctl.alu_src_a;
    assign ALUSrcB   = w_ctl.alu_src_b;
    assign PCSrc     = w_ctl.pc_src;
    assign PCEn      = (w_ctl.pc_write | (w_ctl.branch & w_take)) & ~RST;
    assign IllegalOp = w_illegal & ~RST;
    assign State     = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: the driver pushes the expected
// output vector for each cycle, a monitor pops and compares on the falling edge.
module tb_mips_multicycle_control;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] Op = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero = 1'b0;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic       PCEn;
    logic [2:0] ALUControl;
    logic       IllegalOp;
    logic [3:0] State;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic       pcen;
        logic [2:0] aluctl;
        logic       illegal;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    mips_multicycle_control dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl),
        .IllegalOp(IllegalOp), .State(State)
    );

    // Hand-written table of the outputs each state must show
    function automatic exp_t fx(input int st, input logic [2:0] ctl, input logic pcen, input logic ill);
        exp_t e;
        e = '0;
        e.st = 4'(st);
        e.aluctl = 3'b010;
        case (st)
            0:    begin e.irwrite = 1'b1; e.pcen = 1'b1; e.alusrcb = 2'b01; end
            1:    begin e.alusrcb = 2'b11; e.illegal = ill; end
            2, 9: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            3:    e.iord = 1'b1;
            4:    begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            5:    begin e.iord = 1'b1; e.memwrite = 1'b1; end
            6:    begin e.alusrca = 1'b1; e.aluctl = ctl; end
            7:    begin e.regwrite = 1'b1; e.regdst = 1'b1; end
            8:    begin e.alusrca = 1'b1; e.aluctl = 3'b100; e.pcsrc = 2'b01; e.pcen = pcen; end
            10:   e.regwrite = 1'b1;
            11:   begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic exp_t rexp();
        exp_t e;
        e = fx(0, 3'b010, 1'b0, 1'b0);
        e.irwrite = 1'b0;
        e.pcen = 1'b0;
        return e;
    endfunction

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input exp_t e);
        @(posedge CLK);
        #1;
        RST = r; Op = op; Funct = fn; Zero = z;
        q.push_back(e);
    endtask

    // One instruction: n states, each cycle expecting the listed state's outputs
    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int n, input int s[5], input logic [2:0] ctl,
                         input logic pcen, input logic ill);
        for (int i = 0; i < n; i++)
            step(1'b0, op, fn, z, fx(s[i], ctl, pcen, ill));
    endtask

    // Monitor: compare whenever the driver has queued an expectation
    always @(negedge CLK) begin
        exp_t e, g;
        if (q.size() != 0) begin
            e = q.pop_front();
            g = {State, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, PCSrc, PCEn, ALUControl, IllegalOp};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h (state got %0d exp %0d)",
                         $time, g, e, g.st, e.st);
            end
        end
    end

    initial begin
        int wait_cnt;
        // Reset held for 3 cycles
        repeat (3) step(1'b1, 6'b000000, 6'b000000, 1'b0, rexp());

        // lw: release happens in its FETCH cycle
        instr(6'b100011, 6'b000000, 1'b0, 5, '{0, 1, 2, 3, 4}, 3'b010, 1'b0, 1'b0);
        // R-type variants
        instr(6'b000000, 6'b100010, 1'b0, 4, '{0, 1, 6, 7, 0}, 3'b100, 1'b0, 1'b0);
        instr(6'b000000, 6'b100000, 1'b0, 4, '{0, 1, 6, 7, 0}, 3'b010, 1'b0, 1'b0);
        instr(6'b000000, 6'b100100, 1'b0, 4, '{0, 1, 6, 7, 0}, 3'b000, 1'b0, 1'b0);
        instr(6'b000000, 6'b100101, 1'b0, 4, '{0, 1, 6, 7, 0}, 3'b001, 1'b0, 1'b0);
        instr(6'b000000, 6'b101010, 1'b0, 4, '{0, 1, 6, 7, 0}, 3'b110, 1'b0, 1'b0);
        instr(6'b000000, 6'b011000, 1'b0, 4, '{0, 1, 6, 7, 0}, 3'b101, 1'b0, 1'b0);
        instr(6'b000000, 6'b111111, 1'b0, 4, '{0, 1, 6, 7, 0}, 3'b011, 1'b0, 1'b0);
        // addi
        instr(6'b001000, 6'b000000, 1'b0, 4, '{0, 1, 9, 10, 0}, 3'b010, 1'b0, 1'b0);
        // beq taken / not taken
        instr(6'b000100, 6'b000000, 1'b1, 3, '{0, 1, 8, 0, 0}, 3'b010, 1'b1, 1'b0);
        instr(6'b000100, 6'b000000, 1'b0, 3, '{0, 1, 8, 0, 0}, 3'b010, 1'b0, 1'b0);
        // j
        instr(6'b000010, 6'b000000, 1'b0, 3, '{0, 1, 11, 0, 0}, 3'b010, 1'b0, 1'b0);
        // illegal opcode
        instr(6'b111111, 6'b000000, 1'b0, 2, '{0, 1, 0, 0, 0}, 3'b010, 1'b0, 1'b1);
`ifdef MIPS_CTRL_BNE_EN
        instr(6'b000101, 6'b000000, 1'b0, 3, '{0, 1, 8, 0, 0}, 3'b010, 1'b1, 1'b0);
        instr(6'b000101, 6'b000000, 1'b1, 3, '{0, 1, 8, 0, 0}, 3'b010, 1'b0, 1'b0);
`else
        instr(6'b000101, 6'b000000, 1'b0, 2, '{0, 1, 0, 0, 0}, 3'b010, 1'b0, 1'b1);
`endif
        // beq after bne handling still uses Zero directly
        instr(6'b000100, 6'b000000, 1'b1, 3, '{0, 1, 8, 0, 0}, 3'b010, 1'b1, 1'b0);

        // sw, with reset pulsed while in MEMWR
        instr(6'b101011, 6'b000000, 1'b0, 4, '{0, 1, 2, 5, 0}, 3'b010, 1'b0, 1'b0);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || State !== 4'd0 || RegWrite !== 1'b0 || PCEn !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_memwr got MemWrite=%b State=%0d RegWrite=%b PCEn=%b expected 0/0/0/0",
                     MemWrite, State, RegWrite, PCEn);
        end
        repeat (2) step(1'b1, 6'b101011, 6'b000000, 1'b0, rexp());
        // Resume after reset with an R-type add
        instr(6'b000000, 6'b100000, 1'b0, 4, '{0, 1, 6, 7, 0}, 3'b010, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait
        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 20) begin
            @(posedge CLK);
            wait_cnt++;
        end
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
